// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: tracks in-flight destinations per slot and stalls issue on RAW hazards.
// Build option REG_SCOREBOARD_FORWARD_EN: forwarding from all slots, only load-use in slot 0 stalls.
module reg_scoreboard #(
  parameter int NREG        = 32,
  parameter int AW          = 5,
  parameter int DEPTH       = 3,
  parameter int NSRC        = 2,
  parameter int FLUSH_SLOTS = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   issue_valid_i,
  input  logic [AW-1:0]          issue_rd_i,
  input  logic                   issue_wb_i,
  input  logic                   issue_load_i,
  input  logic [NSRC*AW-1:0]     src_rd_i,
  input  logic [NSRC-1:0]        src_use_i,
  input  logic                   flush_i,
  input  logic                   cnt_clr_i,
  output logic                   stall_o,
  output logic [DEPTH*NREG-1:0]  stage_mask_o,
  output logic [NREG-1:0]        busy_mask_o,
  output logic [15:0]            stall_count_o
);

  // Each slot is held as a one-hot mask; an all-zero mask is an empty slot.
  logic [DEPTH-1:0][NREG-1:0] mask_q, mask_d;
  logic [NREG-1:0]            busy_q, busy_d;
  logic [15:0]                cnt_q, cnt_d;
  logic [NREG-1:0]            issue_oh;
  logic [NREG-1:0]            src_oh;
  logic                       hazard;
  logic                       issue_en;

`ifdef REG_SCOREBOARD_FORWARD_EN
  logic load0_q, load0_d;
`else
  logic unused_load;
  assign unused_load = issue_load_i;
`endif

  // Register 0 is masked out, and indices >= NREG shift out to zero.
  assign issue_oh = (NREG'(1) << issue_rd_i) & ~NREG'(1);

  always_comb begin
    hazard = 1'b0;
    src_oh = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_oh = (NREG'(1) << src_rd_i[i*AW +: AW]) & ~NREG'(1);
      if (src_use_i[i]) begin
`ifdef REG_SCOREBOARD_FORWARD_EN
        if (load0_q && |(mask_q[0] & src_oh)) hazard = 1'b1;
`else
        // Writeback slot excluded: the register file writes before it is read.
        for (int s = 0; s < DEPTH-1; s++) begin
          if (|(mask_q[s] & src_oh)) hazard = 1'b1;
        end
`endif
      end
    end
  end

  assign stall_o  = hazard & issue_valid_i & ~flush_i;
  assign issue_en = issue_valid_i & issue_wb_i & ~stall_o & ~flush_i;

  always_comb begin
    mask_d    = '0;
    mask_d[0] = issue_en ? issue_oh : '0;
    for (int s = 1; s < DEPTH; s++) begin
      mask_d[s] = (flush_i && s < FLUSH_SLOTS) ? '0 : mask_q[s-1];
    end
    busy_d = '0;
    for (int s = 0; s < DEPTH; s++) begin
      busy_d = busy_d | mask_d[s];
    end
  end

`ifdef REG_SCOREBOARD_FORWARD_EN
  assign load0_d = issue_en & issue_load_i;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (stall_o && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mask_q  <= '0;
      busy_q  <= '0;
      cnt_q   <= '0;
`ifdef REG_SCOREBOARD_FORWARD_EN
      load0_q <= 1'b0;
`endif
    end else begin
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
`ifdef REG_SCOREBOARD_FORWARD_EN
      load0_q <= load0_d;
`endif
    end
  end

  assign stage_mask_o  = mask_q;
  assign busy_mask_o   = busy_q;
  assign stall_count_o = cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard; expectations switch on REG_SCOREBOARD_FORWARD_EN.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_wb, issue_load, flush, cnt_clr;
  logic [4:0]  issue_rd;
  logic [9:0]  src_rd;
  logic [1:0]  src_use;
  logic        stall;
  logic [95:0] stage_mask;
  logic [31:0] busy;
  logic [15:0] stall_count;

  logic          b_valid, b_cnt_clr, b_stall;
  logic [2047:0] b_stage;
  logic [31:0]   b_busy;
  logic [15:0]   b_count;

  int n_run = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk_i(clk), .rst_n_i(rst_n), .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
    .issue_wb_i(issue_wb), .issue_load_i(issue_load), .src_rd_i(src_rd), .src_use_i(src_use),
    .flush_i(flush), .cnt_clr_i(cnt_clr), .stall_o(stall), .stage_mask_o(stage_mask),
    .busy_mask_o(busy), .stall_count_o(stall_count)
  );

  // Deep instance with a fixed self-dependent instruction, used for counter saturation.
  reg_scoreboard #(.DEPTH(64)) dut_deep (
    .clk_i(clk), .rst_n_i(rst_n), .issue_valid_i(b_valid), .issue_rd_i(5'd7),
    .issue_wb_i(1'b1), .issue_load_i(1'b0), .src_rd_i(10'd7), .src_use_i(2'b01),
    .flush_i(1'b0), .cnt_clr_i(b_cnt_clr), .stall_o(b_stall), .stage_mask_o(b_stage),
    .busy_mask_o(b_busy), .stall_count_o(b_count)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    issue_valid = 1'b0; issue_rd = '0; issue_wb = 1'b0; issue_load = 1'b0;
    src_rd = '0; src_use = '0; flush = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic drain();
    clr_in();
    repeat (4) tick();
  endtask

  // Issue rd=7 (load=ld), then hold a dependent reading r7 and count stalled cycles.
  task automatic run_dep(input logic ld, input int exp_n);
    int n;
    issue_valid = 1'b1; issue_rd = 5'd7; issue_wb = 1'b1; issue_load = ld; src_use = '0;
    tick();
    issue_rd = 5'd10; issue_load = 1'b1; src_rd = 10'd7; src_use = 2'b01;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (!stall) break;
      n++;
      @(posedge clk);
    end
    chk("dep_stalls", 128'(n), 128'(exp_n));
    tick();
    chk("dep_issued", 128'(stage_mask[31:0]), 128'h400);
    exp_cnt += exp_n;
    clr_in();
  endtask

  initial begin
    rst_n = 1'b0; b_valid = 1'b0; b_cnt_clr = 1'b0;
    clr_in();
    #2;
    chk("rst_stage", 128'(stage_mask), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_stall", 128'(stall), 128'h0);
    chk("rst_count", 128'(stall_count), 128'h0);
    tick(); tick();
    rst_n = 1'b1;

    // single entry walks the pipeline
    issue_valid = 1'b1; issue_rd = 5'd5; issue_wb = 1'b1;
    tick(); clr_in();
    chk("walk_s0", 128'(stage_mask), 128'(1) << 5);
    chk("walk_busy1", 128'(busy), 128'h20);
    tick();
    chk("walk_s1", 128'(stage_mask), 128'(1) << 37);
    tick();
    chk("walk_s2", 128'(stage_mask), 128'(1) << 69);
    chk("walk_busy3", 128'(busy), 128'h20);
    tick();
    chk("walk_gone", 128'(stage_mask), 128'h0);
    chk("walk_busy4", 128'(busy), 128'h0);

`ifdef REG_SCOREBOARD_FORWARD_EN
    run_dep(1'b1, 1);
`else
    run_dep(1'b0, 2);
`endif
    // slot 0 now holds r10 (load); probe port 1, SrcUse, IssueValid and Flush gating
    issue_valid = 1'b1; issue_rd = 5'd11; src_rd = {5'd10, 5'd0}; src_use = 2'b00;
    #1 chk("p1_unused", 128'(stall), 128'h0);
    src_use = 2'b10;
    #1 chk("p1_hazard", 128'(stall), 128'h1);
    issue_valid = 1'b0;
    #1 chk("p1_novalid", 128'(stall), 128'h0);
    issue_valid = 1'b1; flush = 1'b1;
    #1 chk("p1_flush", 128'(stall), 128'h0);
    drain();
`ifdef REG_SCOREBOARD_FORWARD_EN
    run_dep(1'b0, 0);
`else
    run_dep(1'b1, 2);
`endif
    chk("count_after_dep", 128'(stall_count), 128'(exp_cnt));
    drain();

    // register 0 is never tracked nor a hazard
    issue_valid = 1'b1; issue_rd = 5'd0; issue_wb = 1'b1; src_rd = '0; src_use = 2'b11;
    #1 chk("r0_stall", 128'(stall), 128'h0);
    tick();
    chk("r0_stage", 128'(stage_mask), 128'h0);
    clr_in(); tick();
    chk("r0_busy", 128'(busy), 128'h0);

    // flush clears the two youngest slots only
    issue_valid = 1'b1; issue_wb = 1'b1; issue_rd = 5'd3; tick();
    issue_rd = 5'd4; tick();
    issue_rd = 5'd9; flush = 1'b1; tick();
    clr_in();
    chk("flush_stage", 128'(stage_mask), 128'(1) << 67);
    chk("flush_busy", 128'(busy), 128'h8);
    drain();

    // asynchronous reset with three valid slots and an active stall
    issue_valid = 1'b1; issue_wb = 1'b1; issue_load = 1'b1;
    issue_rd = 5'd1; tick();
    issue_rd = 5'd2; tick();
    issue_rd = 5'd6; tick();
    issue_rd = 5'd12; src_rd = 10'd6; src_use = 2'b01;
    #1;
    chk("pre_rst_stall", 128'(stall), 128'h1);
    chk("pre_rst_busy", 128'(busy), 128'h46);
    chk("pre_rst_count", 128'(stall_count), 128'(exp_cnt));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stage", 128'(stage_mask), 128'h0);
    chk("mid_rst_busy", 128'(busy), 128'h0);
    chk("mid_rst_stall", 128'(stall), 128'h0);
    chk("mid_rst_count", 128'(stall_count), 128'h0);
    clr_in(); tick();
    rst_n = 1'b1;

    // CntClr clears the counter (and wins over a concurrent stall without forwarding)
    issue_valid = 1'b1; issue_wb = 1'b1; issue_rd = 5'd7; issue_load = 1'b1; tick();
    issue_rd = 5'd10; src_rd = 10'd7; src_use = 2'b01; tick();
    chk("clr_pre", 128'(stall_count), 128'h1);
    cnt_clr = 1'b1; tick();
    chk("clr_post", 128'(stall_count), 128'h0);
    drain();

`ifndef REG_SCOREBOARD_FORWARD_EN
    // deep instance: 63 stalls per 64 cycles, saturates well before 67064 cycles
    b_valid = 1'b1;
    repeat (64) tick();
    chk("deep_count63", 128'(b_count), 128'd63);
    chk("deep_nostall", 128'(b_stall), 128'h0);
    repeat (67000) tick();
    chk("deep_saturate", 128'(b_count), 128'hFFFF);
    b_cnt_clr = 1'b1; tick();
    chk("deep_clear", 128'(b_count), 128'h0);
    b_cnt_clr = 1'b0; b_valid = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
